// File: rtl/w_ptr_full_handler.sv
// Write-clock pointer and flag logic for the async FIFO: binary/Gray write pointers,
// memory write strobe/address, registered FULL/ALMOST_FULL/level and sticky OVERFLOW.
module w_ptr_full_handler #(
  parameter int PTR_WIDTH    = 10,
  parameter int AFULL_THRESH = 2**(PTR_WIDTH-1) - 4
) (
  input  logic                 W_CLK,
  input  logic                 WRST_n,
  input  logic                 W_EN,
  input  logic                 OVF_CLR,
  input  logic [PTR_WIDTH-1:0] G_RPTR_SYNC,
  output logic                 W_INC,
  output logic [PTR_WIDTH-2:0] W_ADDR,
  output logic [PTR_WIDTH-1:0] W_PTR,
  output logic [PTR_WIDTH-1:0] G_WPTR,
  output logic                 FULL,
  output logic                 ALMOST_FULL,
  output logic [PTR_WIDTH-1:0] W_LEVEL,
  output logic                 OVERFLOW
);

  logic [PTR_WIDTH-1:0] b_nxt;
  logic [PTR_WIDTH-1:0] g_nxt;
  logic [PTR_WIDTH-1:0] r_bin;
  logic [PTR_WIDTH-1:0] level_nxt;
  logic [PTR_WIDTH-1:0] full_cmp;
  logic                 full_nxt;
  logic                 afull_nxt;
  logic                 ovf_set;

  assign W_INC  = W_EN & ~FULL;
  assign W_ADDR = W_PTR[PTR_WIDTH-2:0];

  assign b_nxt = W_PTR + {{(PTR_WIDTH-1){1'b0}}, W_INC};
  assign g_nxt = (b_nxt >> 1) ^ b_nxt;

  // Each binary bit is the XOR of the Gray bits at and above it.
  always_comb begin
    r_bin = '0;
    for (int unsigned i = 0; i < PTR_WIDTH; i++) begin
      r_bin[i] = ^(G_RPTR_SYNC >> i);
    end
  end

  assign full_cmp  = {~G_RPTR_SYNC[PTR_WIDTH-1:PTR_WIDTH-2], G_RPTR_SYNC[PTR_WIDTH-3:0]};
  assign full_nxt  = (g_nxt == full_cmp);
  assign level_nxt = b_nxt - r_bin;
  assign afull_nxt = (level_nxt >= PTR_WIDTH'(AFULL_THRESH));
  assign ovf_set   = W_EN & FULL;

  always_ff @(posedge W_CLK or negedge WRST_n) begin
    if (!WRST_n) begin
      W_PTR       <= '0;
      G_WPTR      <= '0;
      FULL        <= 1'b0;
      ALMOST_FULL <= 1'b0;
      W_LEVEL     <= '0;
      OVERFLOW    <= 1'b0;
    end else begin
      W_PTR       <= b_nxt;
      G_WPTR      <= g_nxt;
      FULL        <= full_nxt;
      ALMOST_FULL <= afull_nxt;
      W_LEVEL     <= level_nxt;
      if (ovf_set)
        OVERFLOW <= 1'b1;
      else if (OVF_CLR)
        OVERFLOW <= 1'b0;
    end
  end

endmodule

// File: tb/tb_w_ptr_full_handler.sv
// Self-checking bench for w_ptr_full_handler: directed scenarios plus random traffic
// compared against a counting model of the write side.
module tb_w_ptr_full_handler;

  localparam int PW    = 4;
  localparam int DEPTH = 8;
  localparam int AT    = 6;

  logic          W_CLK = 1'b0;
  logic          WRST_n;
  logic          W_EN;
  logic          OVF_CLR;
  logic [PW-1:0] G_RPTR_SYNC;
  logic          W_INC;
  logic [PW-2:0] W_ADDR;
  logic [PW-1:0] W_PTR;
  logic [PW-1:0] G_WPTR;
  logic          FULL;
  logic          ALMOST_FULL;
  logic [PW-1:0] W_LEVEL;
  logic          OVERFLOW;

  int errors = 0;
  int checks = 0;
  int m_wptr, m_level, m_full, m_af, m_ovf;

  w_ptr_full_handler #(.PTR_WIDTH(PW), .AFULL_THRESH(AT)) dut (
    .W_CLK(W_CLK), .WRST_n(WRST_n), .W_EN(W_EN), .OVF_CLR(OVF_CLR),
    .G_RPTR_SYNC(G_RPTR_SYNC), .W_INC(W_INC), .W_ADDR(W_ADDR), .W_PTR(W_PTR),
    .G_WPTR(G_WPTR), .FULL(FULL), .ALMOST_FULL(ALMOST_FULL), .W_LEVEL(W_LEVEL),
    .OVERFLOW(OVERFLOW)
  );

  always #5 W_CLK = ~W_CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic int gray(int b);
    return (b ^ (b >> 1)) & 15;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wptr = 0; m_level = 0; m_full = 0; m_af = 0; m_ovf = 0;
  endtask

  task automatic check_outputs();
    check("w_ptr",   W_PTR,       m_wptr);
    check("g_wptr",  G_WPTR,      gray(m_wptr));
    check("w_addr",  W_ADDR,      m_wptr % DEPTH);
    check("full",    FULL,        m_full);
    check("afull",   ALMOST_FULL, m_af);
    check("level",   W_LEVEL,     m_level);
    check("ovf",     OVERFLOW,    m_ovf);
    check("inv_full", FULL, (W_LEVEL == DEPTH) ? 1 : 0);
  endtask

  // One clock: drive at negedge, check strobe, advance model, check registers at next negedge.
  task automatic cycle(input int en, input int clr, input int rb);
    int inc;
    W_EN        = en[0];
    OVF_CLR     = clr[0];
    G_RPTR_SYNC = PW'(gray(rb));
    #1;
    inc = (en != 0 && m_full == 0) ? 1 : 0;
    check("w_inc", W_INC, inc);
    if (en != 0 && m_full != 0) m_ovf = 1;
    else if (clr != 0)          m_ovf = 0;
    m_wptr  = (m_wptr + inc) % 16;
    m_level = (m_wptr - rb + 16) % 16;
    m_full  = (m_level == DEPTH) ? 1 : 0;
    m_af    = (m_level >= AT) ? 1 : 0;
    @(posedge W_CLK);
    @(negedge W_CLK);
    check_outputs();
  endtask

  task automatic do_reset();
    W_EN = 1'b0; OVF_CLR = 1'b0; G_RPTR_SYNC = '0;
    WRST_n = 1'b0;
    @(negedge W_CLK);
    WRST_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int incs, wraps, rb, rc;
    logic [PW-1:0] prev_g, prev_p;

    // 1. reset with write request and arbitrary read pointer
    WRST_n = 1'b0; W_EN = 1'b1; OVF_CLR = 1'b0;
    G_RPTR_SYNC = PW'($urandom_range(15, 0));
    model_reset();
    @(negedge W_CLK);
    @(negedge W_CLK);
    check_outputs();
    check("rst_w_inc", W_INC, 1);
    W_EN = 1'b0; G_RPTR_SYNC = '0; WRST_n = 1'b1;

    // asynchronous reset mid-fill at level 5
    for (int i = 0; i < 5; i++) cycle(1, 0, 0);
    check("pre_rst_level", W_LEVEL, 5);
    #2 WRST_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    W_EN = 1'b0;
    #1 WRST_n = 1'b1;
    @(negedge W_CLK);

    // 2. fill against a stationary read pointer
    do_reset();
    incs = 0;
    for (int i = 1; i <= 10; i++) begin
      W_EN = 1'b1; #1;
      if (W_INC) incs++;
      #0;
      cycle(1, 0, 0);
      check("fill_afull_edge", ALMOST_FULL, (i >= 6) ? 1 : 0);
      if (i == 8) begin
        check("fill_full", FULL, 1);
        check("fill_ptr", W_PTR, 8);
        check("fill_gray", G_WPTR, 12);
        check("fill_level", W_LEVEL, 8);
      end
      if (i == 9) check("fill_ovf", OVERFLOW, 1);
    end
    check("fill_inc_count", incs, 8);

    // 3. release by a read-pointer jump to 3
    cycle(0, 0, 3);
    check("rel_full", FULL, 0);
    check("rel_level", W_LEVEL, 5);
    check("rel_afull", ALMOST_FULL, 0);
    cycle(1, 0, 3);
    check("rel_level6", W_LEVEL, 6);

    // 4. wrap with the read pointer trailing by two
    do_reset();
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    wraps = 0;
    for (int i = 0; i < 20; i++) begin
      prev_g = G_WPTR;
      prev_p = W_PTR;
      rb = (m_wptr + 15) % 16;
      cycle(1, 0, rb);
      check("wrap_onebit", $countones(prev_g ^ G_WPTR), 1);
      check("wrap_level", W_LEVEL, 2);
      check("wrap_nofull", FULL, 0);
      if (prev_p == 4'd15) begin
        wraps++;
        check("wrap_ptr0", W_PTR, 0);
        check("wrap_gprev", prev_g, 8);
        check("wrap_g0", G_WPTR, 0);
      end
    end
    check("wrap_seen", wraps, 1);

    // 5. simultaneous write and read advance at level 7, then overflow set/clear priority
    do_reset();
    for (int i = 0; i < 7; i++) cycle(1, 0, 0);
    check("sim_level7", W_LEVEL, 7);
    cycle(1, 0, 1);
    check("sim_level_hold", W_LEVEL, 7);
    check("sim_nofull", FULL, 0);
    cycle(1, 0, 1);
    check("sim_full", FULL, 1);
    cycle(1, 0, 1);
    check("sim_ovf_set", OVERFLOW, 1);
    cycle(1, 1, 1);
    check("sim_set_wins", OVERFLOW, 1);
    cycle(0, 1, 1);
    check("sim_ovf_clr", OVERFLOW, 0);

    // random traffic with a legally lagging read pointer
    do_reset();
    rc = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(2, 0) == 0 && ((m_wptr - rc + 16) % 16) > 0) rc = (rc + 1) % 16;
      cycle(($urandom_range(3, 0) != 0) ? 1 : 0, ($urandom_range(15, 0) == 0) ? 1 : 0, rc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/w_ptr_full_handler.md
# w_ptr_full_handler

Write-side pointer and flag generator for the asynchronous FIFO, in the W_CLK domain directly upstream of the read-pointer handler. Keeps the binary and Gray write pointers and produces the memory write strobe and address. Compares against the read pointer after it has been synchronized into W_CLK, and from that produces registered FULL, ALMOST_FULL, fill level and a sticky overflow flag. G_WPTR is the value the write-to-read synchronizer carries to the read side.

## Interface
- PTR_WIDTH, 10, pointer width; MSB is the wrap bit; DEPTH = 2^(PTR_WIDTH-1); legal values ≥ 3
- AFULL_THRESH, 2^(PTR_WIDTH-1)-4, level at or above which ALMOST_FULL asserts; legal values 1..DEPTH

- W_CLK  in  1  write clock; all state changes on its rising edge
- WRST_n  in  1  asynchronous, active-low reset
- W_EN  in  1  write request from the producer
- OVF_CLR  in  1  synchronous clear of OVERFLOW
- G_RPTR_SYNC  in  PTR_WIDTH  Gray read pointer, already synchronized into W_CLK
- W_INC  out  1  memory write strobe (combinational)
- W_ADDR  out  PTR_WIDTH-1  memory write address, equal to W_PTR[PTR_WIDTH-2:0]
- W_PTR  out  PTR_WIDTH  binary write pointer (registered)
- G_WPTR  out  PTR_WIDTH  Gray write pointer (registered), sent to the synchronizer
- FULL  out  1  registered full flag
- ALMOST_FULL  out  1  registered, asserted when level ≥ AFULL_THRESH
- W_LEVEL  out  PTR_WIDTH  registered fill count, range 0..DEPTH
- OVERFLOW  out  1  sticky flag: a write was attempted while FULL

## Operation
- W_INC = W_EN & ~FULL. A write while FULL is dropped: no pointer change and no memory write.
- B_NXT = W_PTR + W_INC, modulo 2^PTR_WIDTH. The pointer wraps from all-ones to 0.
- G_NXT = (B_NXT >> 1) ^ B_NXT.
- Read pointer Gray-to-binary conversion: R_BIN[i] = XOR of G_RPTR_SYNC[PTR_WIDTH-1:i].
- FULL_NXT = (G_NXT == {~G_RPTR_SYNC[PTR_WIDTH-1:PTR_WIDTH-2], G_RPTR_SYNC[PTR_WIDTH-3:0]}).
- LEVEL_NXT = (B_NXT - R_BIN) modulo 2^PTR_WIDTH.
- ALMOST_FULL_NXT = (LEVEL_NXT ≥ AFULL_THRESH).
- Registered on each W_CLK edge: W_PTR←B_NXT, G_WPTR←G_NXT, FULL←FULL_NXT, W_LEVEL←LEVEL_NXT, ALMOST_FULL←ALMOST_FULL_NXT.
- OVERFLOW:
  - sets when W_EN & FULL;
  - clears when OVF_CLR and no set condition in the same cycle (set wins over clear);
  - otherwise holds.
- Required invariants:
  - FULL == (W_LEVEL == DEPTH);
  - W_LEVEL never exceeds DEPTH;
  - G_WPTR changes by exactly one bit per write.
- No state machine beyond the pointer/flag registers. The block is a single-stage, registered-output pipeline.

## Timing
- Reset, asynchronous on WRST_n low: W_PTR=0, G_WPTR=0, W_ADDR=0, FULL=0, ALMOST_FULL=0, W_LEVEL=0, OVERFLOW=0. W_INC then follows W_EN.
- Reset mid-operation clears all state immediately, regardless of W_CLK. The read domain must be reset in the same event; behaviour under a one-sided reset is undefined.
- Accepted write: W_INC is high in the same cycle as W_EN. W_PTR, G_WPTR and W_ADDR advance on that edge.
- FULL asserts on the edge that accepts the write filling the last slot. A W_EN in the following cycle is blocked.
- A change of G_RPTR_SYNC is reflected in FULL, ALMOST_FULL and W_LEVEL one W_CLK edge later.
- Flags are pessimistic, because the read pointer lags by the synchronizer depth:
  - FULL may be held longer than strictly necessary;
  - FULL is never deasserted early.
- Simultaneous accepted write and read-pointer advance: the level is unchanged.

## Test plan
All scenarios use PTR_WIDTH=4 (DEPTH 8) and AFULL_THRESH=6.

1. Reset: hold WRST_n=0 with W_EN=1 and random G_RPTR_SYNC -> all registered outputs 0 and W_INC=1. Pulse reset mid-fill at level 5 -> outputs return to 0 asynchronously, before the next W_CLK.
2. Fill: G_RPTR_SYNC=4'b0000, W_EN=1 for 10 cycles ->
   - W_INC high for exactly 8 cycles;
   - ALMOST_FULL rises on the 6th edge;
   - FULL=1 after the 8th edge, with W_PTR=4'b1000, G_WPTR=4'b1100, W_LEVEL=8;
   - OVERFLOW=1 after the 9th edge.
3. Release: from full, set G_RPTR_SYNC=4'b0010 (binary 3) -> after one edge FULL=0, W_LEVEL=5, ALMOST_FULL=0. The next W_EN is accepted and W_LEVEL becomes 6.
4. Wrap: 20 writes with G_RPTR_SYNC tracking W_PTR-2 ->
   - W_PTR wraps from 15 to 0 and G_WPTR goes 4'b1000 -> 4'b0000;
   - FULL never asserts and W_LEVEL stays 2;
   - exactly one G_WPTR bit toggles per write.
5. Simultaneous events at W_LEVEL=7:
   - W_EN=1 while G_RPTR_SYNC advances by one -> W_LEVEL stays 7 and FULL stays 0;
   - at FULL, OVF_CLR=1 together with W_EN=1 -> OVERFLOW stays 1;
   - OVF_CLR=1 with W_EN=0 -> OVERFLOW=0 after one edge.
